// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsk_pkg
// Description : Shared types and helper functions for the M-ary FSK DCO
//               controller (state encoding, default tone levels, stepping).
// Revision    : 1.0 - initial release
// ============================================================================
package fsk_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } fsk_state_t;

  localparam int c_HOLD_W = 16;

  // Evenly spaced default tone: floor(i*code_w/(m-1)); a single tone sits at 0
  function automatic int default_level(input int i, input int m, input int code_w);
    if (m <= 1) return 0;
    return (i * code_w) / (m - 1);
  endfunction

  // Move cur toward tgt by at most step, never overshooting
  function automatic int step_toward(input int cur, input int tgt, input int step);
    if (tgt > cur) return ((tgt - cur) > step) ? (cur + step) : tgt;
    if (cur > tgt) return ((cur - tgt) > step) ? (cur - step) : tgt;
    return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_therm_enc.sv
`default_nettype none
// ============================================================================
// Module      : fsk_therm_enc
// Description : Combinational level-to-thermometer decoder. Bit i of the
//               output is set when the level exceeds i.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_therm_enc #(
  parameter int CODE_W = 129,
  parameter int LVL_W  = $clog2(CODE_W + 1)
) (
  input  logic [LVL_W-1:0]  LEVEL,
  output logic [CODE_W-1:0] THERM
);

  // One comparator per thermometer bit
  for (genvar i = 0; i < CODE_W; i++) begin : g_therm
    assign THERM[i] = (LEVEL > LVL_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/fsk_mfsk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fsk_mfsk_ctrl
// Description : M-ary FSK DCO controller. Accepts symbols over valid/ready,
//               maps them through a programmable tone table, optionally ramps
//               the thermometer code in bounded steps, then holds each tone
//               for a programmable number of cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_mfsk_ctrl
  import fsk_pkg::*;
#(
  parameter int CODE_W    = 129,
  parameter int SYM_BITS  = 2,
  parameter int RAMP_STEP = 8,
  parameter int LVL_W     = $clog2(CODE_W + 1)
) (
  input  logic                TX_CLK,
  input  logic                RESET,
  input  logic                TX_VALID,
  input  logic [SYM_BITS-1:0] TX_SYM,
  output logic                TX_READY,
  input  logic                RAMP_EN,
  input  logic [15:0]         HOLD_CYC,
  input  logic                TONE_WE,
  input  logic [SYM_BITS-1:0] TONE_ADDR,
  input  logic [LVL_W-1:0]    TONE_LEVEL,
  output logic [CODE_W-1:0]   DCO_CODE,
  output logic [LVL_W-1:0]    CUR_LEVEL,
  output logic                BUSY
);

  localparam int               c_M       = 1 << SYM_BITS;
  localparam logic [LVL_W-1:0] c_LVL_MAX = LVL_W'(CODE_W);

  fsk_state_t              r_state, w_state_nxt;
  logic [LVL_W-1:0]        r_cur_level, w_level_nxt;
  logic [LVL_W-1:0]        r_target, w_target_nxt;
  logic [c_HOLD_W-1:0]     r_cnt, w_cnt_nxt;
  logic [LVL_W-1:0]        r_tbl [c_M];

  logic [LVL_W-1:0]        w_sym_lvl;
  logic [LVL_W-1:0]        w_tone_wr_lvl;
  logic [LVL_W-1:0]        w_accept_lvl;
  logic [LVL_W-1:0]        w_ramp_lvl;
  logic [c_HOLD_W-1:0]     w_hold_init;
  logic                    w_ready;
  int                      w_step;

  // A jump is a step large enough to cover any distance in one cycle
  assign w_step        = RAMP_EN ? RAMP_STEP : CODE_W;
  assign w_sym_lvl     = r_tbl[TX_SYM];
  assign w_tone_wr_lvl = (TONE_LEVEL > c_LVL_MAX) ? c_LVL_MAX : TONE_LEVEL;
  assign w_hold_init   = (HOLD_CYC == 16'd0) ? 16'd0 : (HOLD_CYC - 16'd1);
  assign w_accept_lvl  = LVL_W'(step_toward(int'(r_cur_level), int'(w_sym_lvl), w_step));
  assign w_ramp_lvl    = LVL_W'(step_toward(int'(r_cur_level), int'(r_target), w_step));

  // Tone table: defaults on reset, clamped writes otherwise. Accepts read the
  // pre-edge contents, so a same-edge write never affects the latched target.
  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < c_M; i++) begin
        r_tbl[i] <= LVL_W'(default_level(i, c_M, CODE_W));
      end
    end else if (TONE_WE) begin
      r_tbl[TONE_ADDR] <= w_tone_wr_lvl;
    end
  end

  // State and datapath registers
  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cur_level <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_level <= w_level_nxt;
      r_target    <= w_target_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Next-state, level stepping and ready generation
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_cur_level;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_ready      = 1'b0;

    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      RAMP: begin
        w_level_nxt = w_ramp_lvl;
        if (w_ramp_lvl == r_target) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = w_hold_init;
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_ready     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Accept takes the first step on the same edge; a zero-distance symbol
    // goes straight to HOLD so it is still held for its full duration.
    if (w_ready && TX_VALID) begin
      w_target_nxt = w_sym_lvl;
      w_level_nxt  = w_accept_lvl;
      if (w_accept_lvl == w_sym_lvl) begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = w_hold_init;
      end else begin
        w_state_nxt = RAMP;
      end
    end
  end

  assign TX_READY  = w_ready;
  assign BUSY      = (r_state != IDLE);
  assign CUR_LEVEL = r_cur_level;

  fsk_therm_enc #(
    .CODE_W (CODE_W),
    .LVL_W  (LVL_W)
  ) u_therm_enc (
    .LEVEL (r_cur_level),
    .THERM (DCO_CODE)
  );

endmodule
`default_nettype wire

// File: tb/tb_fsk_mfsk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsk_mfsk_ctrl
// Description : Directed bench for fsk_mfsk_ctrl. Stimulus pushes the state
//               expected after each edge into a queue; a monitor pops and
//               compares shortly after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_mfsk_ctrl;

  localparam int CODE_W   = 129;
  localparam int SYM_BITS = 2;
  localparam int LVL_W    = 8;

  logic                TX_CLK = 1'b0;
  logic                RESET;
  logic                TX_VALID;
  logic [SYM_BITS-1:0] TX_SYM;
  logic                TX_READY;
  logic                RAMP_EN;
  logic [15:0]         HOLD_CYC;
  logic                TONE_WE;
  logic [SYM_BITS-1:0] TONE_ADDR;
  logic [LVL_W-1:0]    TONE_LEVEL;
  logic [CODE_W-1:0]   DCO_CODE;
  logic [LVL_W-1:0]    CUR_LEVEL;
  logic                BUSY;

  typedef struct {
    string nm;
    int    lvl;
    bit    rdy;
    bit    bsy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fsk_mfsk_ctrl #(
    .CODE_W    (CODE_W),
    .SYM_BITS  (SYM_BITS),
    .RAMP_STEP (8),
    .LVL_W     (LVL_W)
  ) dut (
    .TX_CLK     (TX_CLK),
    .RESET      (RESET),
    .TX_VALID   (TX_VALID),
    .TX_SYM     (TX_SYM),
    .TX_READY   (TX_READY),
    .RAMP_EN    (RAMP_EN),
    .HOLD_CYC   (HOLD_CYC),
    .TONE_WE    (TONE_WE),
    .TONE_ADDR  (TONE_ADDR),
    .TONE_LEVEL (TONE_LEVEL),
    .DCO_CODE   (DCO_CODE),
    .CUR_LEVEL  (CUR_LEVEL),
    .BUSY       (BUSY)
  );

  always #5 TX_CLK = ~TX_CLK;

  function automatic logic [CODE_W-1:0] therm(input int l);
    logic [CODE_W-1:0] t;
    for (int i = 0; i < CODE_W; i++) t[i] = (i < l);
    return t;
  endfunction

  task automatic compare(input string nm, input int lvl, input bit rdy, input bit bsy);
    n_checks += 4;
    if (int'(CUR_LEVEL) != lvl) begin
      n_fail++;
      $display("FAIL %s CUR_LEVEL got %0d want %0d", nm, CUR_LEVEL, lvl);
    end
    if (DCO_CODE !== therm(lvl)) begin
      n_fail++;
      $display("FAIL %s DCO_CODE got %h want %h", nm, DCO_CODE, therm(lvl));
    end
    if (TX_READY !== rdy) begin
      n_fail++;
      $display("FAIL %s TX_READY got %b want %b", nm, TX_READY, rdy);
    end
    if (BUSY !== bsy) begin
      n_fail++;
      $display("FAIL %s BUSY got %b want %b", nm, BUSY, bsy);
    end
  endtask

  // Monitor: check the post-edge state against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge TX_CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e.nm, e.lvl, e.rdy, e.bsy);
      end
    end
  end

  // Drive one cycle of inputs and record what the following edge must produce
  task automatic cyc(input bit v, input int s, input string nm,
                     input int lvl, input bit rdy, input bit bsy);
    exp_t e;
    TX_VALID = v;
    TX_SYM   = SYM_BITS'(s);
    e.nm = nm; e.lvl = lvl; e.rdy = rdy; e.bsy = bsy;
    q.push_back(e);
    @(negedge TX_CLK);
  endtask

  // Remaining HOLD cycles (HOLD_CYC=4) after the entry edge, then IDLE
  task automatic hold_tail(input string nm, input int lvl);
    cyc(0, 0, nm, lvl, 1'b0, 1'b1);
    cyc(0, 0, nm, lvl, 1'b0, 1'b1);
    cyc(0, 0, nm, lvl, 1'b1, 1'b1);
    cyc(0, 0, {nm, "_idle"}, lvl, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; TX_VALID = 1'b0; TX_SYM = '0; RAMP_EN = 1'b0;
    HOLD_CYC = 16'd4; TONE_WE = 1'b0; TONE_ADDR = '0; TONE_LEVEL = '0;
    #1;
    compare("reset_async", 0, 1'b1, 1'b0);
    repeat (2) @(negedge TX_CLK);
    RESET = 1'b0;
    cyc(0, 0, "rst_idle", 0, 1'b1, 1'b0);

    // Ramp 0 -> 43
    RAMP_EN = 1'b1;
    cyc(1, 1, "up", 8, 1'b0, 1'b1);
    cyc(0, 0, "up", 16, 1'b0, 1'b1);
    cyc(0, 0, "up", 24, 1'b0, 1'b1);
    cyc(0, 0, "up", 32, 1'b0, 1'b1);
    cyc(0, 0, "up", 40, 1'b0, 1'b1);
    cyc(0, 0, "up_end", 43, 1'b0, 1'b1);
    hold_tail("up_hold", 43);

    // Jump 43 -> 129
    RAMP_EN = 1'b0;
    cyc(1, 3, "jump", 129, 1'b0, 1'b1);
    hold_tail("jump_hold", 129);

    // Ramp 129 -> 0 in 17 steps
    RAMP_EN = 1'b1;
    cyc(1, 0, "down", 121, 1'b0, 1'b1);
    for (int k = 2; k <= 16; k++) cyc(0, 0, "down", 129 - 8 * k, 1'b0, 1'b1);
    cyc(0, 0, "down_end", 0, 1'b0, 1'b1);
    hold_tail("down_hold", 0);

    // Back-to-back symbols with TX_VALID held
    RAMP_EN = 1'b0;
    cyc(1, 2, "b2b", 86, 1'b0, 1'b1);
    cyc(1, 1, "b2b", 86, 1'b0, 1'b1);
    cyc(1, 1, "b2b", 86, 1'b0, 1'b1);
    cyc(1, 1, "b2b", 86, 1'b1, 1'b1);
    cyc(1, 1, "b2b_next", 43, 1'b0, 1'b1);
    hold_tail("b2b_hold", 43);

    // Same-level symbol still holds
    RAMP_EN = 1'b1;
    cyc(1, 1, "same", 43, 1'b0, 1'b1);
    hold_tail("same_hold", 43);

    // Clamped table write, then use it
    TONE_WE = 1'b1; TONE_ADDR = 2'd2; TONE_LEVEL = 8'd200;
    cyc(0, 0, "wr_clamp", 43, 1'b1, 1'b0);
    TONE_WE = 1'b0;
    RAMP_EN = 1'b0;
    cyc(1, 2, "clamp", 129, 1'b0, 1'b1);
    hold_tail("clamp_hold", 129);

    // Ramp 129 -> 43 with a rewrite of entry 1 in flight
    RAMP_EN = 1'b1;
    cyc(1, 1, "midwr", 121, 1'b0, 1'b1);
    cyc(0, 0, "midwr", 113, 1'b0, 1'b1);
    TONE_WE = 1'b1; TONE_ADDR = 2'd1; TONE_LEVEL = 8'd60;
    cyc(0, 0, "midwr", 105, 1'b0, 1'b1);
    TONE_WE = 1'b0;
    for (int k = 4; k <= 10; k++) cyc(0, 0, "midwr", 129 - 8 * k, 1'b0, 1'b1);
    cyc(0, 0, "midwr_end", 43, 1'b0, 1'b1);
    hold_tail("midwr_hold", 43);
    RAMP_EN = 1'b0;
    cyc(1, 1, "new60", 60, 1'b0, 1'b1);
    hold_tail("new60_hold", 60);

    // HOLD_CYC=0 behaves as a single hold cycle
    HOLD_CYC = 16'd0;
    cyc(1, 0, "hold0", 0, 1'b1, 1'b1);
    cyc(0, 0, "hold0_idle", 0, 1'b1, 1'b0);
    HOLD_CYC = 16'd4;

    // Reset in the middle of a ramp toward 60
    RAMP_EN = 1'b1;
    cyc(1, 1, "pre_rst", 8, 1'b0, 1'b1);
    cyc(0, 0, "pre_rst", 16, 1'b0, 1'b1);
    cyc(0, 0, "pre_rst", 24, 1'b0, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    compare("mid_rst", 0, 1'b1, 1'b0);
    @(negedge TX_CLK);
    RESET = 1'b0;
    RAMP_EN = 1'b0;
    cyc(1, 2, "post_rst", 86, 1'b0, 1'b1);
    hold_tail("post_rst_hold", 86);

    repeat (2) @(negedge TX_CLK);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
